// File: rtl/wb_retire_queue.sv
// wb_retire_queue: in-order writeback queue between execute/mem and the register file.
// Completed instructions wait here until any load data returns from the dcache. The load data
// is aligned and sign/zero extended, and one register-file write retires per cycle in program order.
// Optional feature: define WB_FORWARD_EN to add the fwd_valid/fwd_rd/fwd_data bypass outputs.
module wb_retire_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int RA_W  = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_alu,
  input  logic [2:0]                 in_funct3,
  input  logic [RA_W-1:0]            in_rd,
  input  logic                       in_reg_we,
  input  logic                       in_mem_rr,
  input  logic                       in_do_jump,
  input  logic                       dc_resp_valid,
  input  logic [XLEN-1:0]            dc_resp_data,
  output logic                       rf_we,
  output logic [RA_W-1:0]            rf_waddr,
  output logic [XLEN-1:0]            rf_wdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       resp_err
`ifdef WB_FORWARD_EN
  ,
  output logic                       fwd_valid,
  output logic [RA_W-1:0]            fwd_rd,
  output logic [XLEN-1:0]            fwd_data
`endif
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int OFFW = $clog2(XLEN / 8);

  // Entry storage. For an incomplete load, ent_data holds the load address until data arrives.
  logic [XLEN-1:0] ent_data [DEPTH];
  logic [RA_W-1:0] ent_rd   [DEPTH];
  logic            ent_we   [DEPTH];
  logic [2:0]      ent_f3   [DEPTH];
  logic            ent_done [DEPTH];

  // Slot indices of incomplete loads, oldest first; its head is the fill pointer.
  logic [PW-1:0]   lq_idx   [DEPTH];

  logic [PW-1:0]   head_reg, tail_reg, lq_head_reg, lq_tail_reg;
  logic [CW-1:0]   count_reg, lq_cnt_reg;

  logic            enq, enq_load, fill, head_fill, ret, ret_we;
  logic [PW-1:0]   fill_idx;
  logic [XLEN-1:0] fill_value, ret_data, enq_data;

  // Select and extend the addressed byte/half/word out of the raw dcache word.
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] raw,
                                              input logic [2:0]      f3,
                                              input logic [OFFW-1:0] off);
    logic [OFFW-1:0] off_h, off_w;
    logic [XLEN-1:0] sb, sh, sw, res;
    off_h = off & ~OFFW'(1);
    off_w = off & ~OFFW'(3);
    sb = raw >> {off, 3'b000};
    sh = raw >> {off_h, 3'b000};
    sw = raw >> {off_w, 3'b000};
    case (f3)
      3'b000:  res = XLEN'($signed(sb[7:0]));
      3'b001:  res = XLEN'($signed(sh[15:0]));
      3'b010:  res = XLEN'($signed(sw[31:0]));
      3'b100:  res = XLEN'(sb[7:0]);
      3'b101:  res = XLEN'(sh[15:0]);
      3'b110:  res = (XLEN == 64) ? XLEN'(sw[31:0]) : raw;
      default: res = raw;
    endcase
    return res;
  endfunction

  assign in_ready   = (count_reg < CW'(DEPTH));
  assign count      = count_reg;
  assign enq        = in_valid && in_ready;
  assign enq_load   = enq && in_mem_rr;
  assign enq_data   = (in_reg_we && in_do_jump) ? in_pc + XLEN'(4) : in_alu;

  // A response fills the oldest incomplete load as seen before the edge.
  assign fill       = dc_resp_valid && (lq_cnt_reg != '0);
  assign fill_idx   = lq_idx[lq_head_reg];
  assign fill_value = extract(dc_resp_data, ent_f3[fill_idx], ent_data[fill_idx][OFFW-1:0]);

  // The head retires if already complete, or if it is the load being filled this cycle.
  assign head_fill  = fill && (fill_idx == head_reg);
  assign ret        = (count_reg != '0) && (ent_done[head_reg] || head_fill);
  assign ret_data   = ent_done[head_reg] ? ent_data[head_reg] : fill_value;
  assign ret_we     = ent_we[head_reg] && (ent_rd[head_reg] != '0);

`ifdef WB_FORWARD_EN
  assign fwd_valid  = ret && ret_we;
  assign fwd_rd     = ent_rd[head_reg];
  assign fwd_data   = ret_data;
`endif

  // Entry and load-index storage; contents are don't-care while their slot is unoccupied.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_data[tail_reg] <= enq_data;
      ent_rd[tail_reg]   <= in_rd;
      ent_we[tail_reg]   <= in_reg_we;
      ent_f3[tail_reg]   <= in_funct3;
      ent_done[tail_reg] <= !in_mem_rr;
    end
    if (enq_load) begin
      lq_idx[lq_tail_reg] <= tail_reg;
    end
    if (fill) begin
      ent_data[fill_idx] <= fill_value;
      ent_done[fill_idx] <= 1'b1;
    end
  end

  // Queue pointers, occupancy, load tracking and the sticky response error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      lq_head_reg <= '0;
      lq_tail_reg <= '0;
      lq_cnt_reg  <= '0;
      resp_err    <= 1'b0;
    end else begin
      if (enq)      tail_reg    <= tail_reg + 1'b1;
      if (ret)      head_reg    <= head_reg + 1'b1;
      if (enq_load) lq_tail_reg <= lq_tail_reg + 1'b1;
      if (fill)     lq_head_reg <= lq_head_reg + 1'b1;
      count_reg  <= count_reg + CW'(enq) - CW'(ret);
      lq_cnt_reg <= lq_cnt_reg + CW'(enq_load) - CW'(fill);
      if (dc_resp_valid && (lq_cnt_reg == '0)) resp_err <= 1'b1;
    end
  end

  // Registered register-file write port; address and data hold when nothing retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (ret) begin
      rf_we    <= ret_we;
      rf_waddr <= ent_rd[head_reg];
      rf_wdata <= ret_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed bench for wb_retire_queue (XLEN=32, DEPTH=4, RA_W=5).
module tb_wb_retire_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_alu;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        in_reg_we, in_mem_rr, in_do_jump;
  logic        dc_resp_valid;
  logic [31:0] dc_resp_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  count;
  logic        resp_err;

  int errors = 0;
  int checks = 0;

  wb_retire_queue #(.XLEN(32), .DEPTH(4), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_alu(in_alu),
    .in_funct3(in_funct3), .in_rd(in_rd), .in_reg_we(in_reg_we), .in_mem_rr(in_mem_rr),
    .in_do_jump(in_do_jump), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .count(count), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_pc = 0; in_alu = 0; in_funct3 = 0; in_rd = 0;
    in_reg_we = 0; in_mem_rr = 0; in_do_jump = 0;
    dc_resp_valid = 0; dc_resp_data = 0;
  endtask

  task automatic drive_alu(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] rd,
                           input logic we, input logic jump);
    idle();
    in_valid = 1; in_pc = pc; in_alu = alu; in_rd = rd; in_reg_we = we; in_do_jump = jump;
  endtask

  task automatic drive_load(input logic [31:0] alu, input logic [2:0] f3, input logic [4:0] rd);
    idle();
    in_valid = 1; in_alu = alu; in_funct3 = f3; in_rd = rd; in_reg_we = 1; in_mem_rr = 1;
  endtask

  task automatic resp(input logic [31:0] d);
    idle();
    dc_resp_valid = 1; dc_resp_data = d;
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1;
    tick();

    // ALU op
    drive_alu(32'h0, 32'h1234, 5'd5, 1, 0); tick(); idle();
    chk("alu_count1", count, 1);
    chk("alu_we_early", rf_we, 0);
    tick();
    chk("alu_we", rf_we, 1);
    chk("alu_waddr", rf_waddr, 5);
    chk("alu_wdata", rf_wdata, 32'h1234);
    chk("alu_count0", count, 0);
    tick();
    chk("idle_we", rf_we, 0);
    chk("idle_wdata_hold", rf_wdata, 32'h1234);

    // JAL back-to-back, including pc+4 wrap
    drive_alu(32'h100, 32'hDEAD, 5'd1, 1, 1); tick();
    drive_alu(32'hFFFF_FFFC, 32'hBEEF, 5'd1, 1, 1); tick(); idle();
    chk("jal_we", rf_we, 1);
    chk("jal_wdata", rf_wdata, 32'h104);
    tick();
    chk("jal_wrap_wdata", rf_wdata, 32'h0);
    chk("jal_wrap_waddr", rf_waddr, 1);

    // LB and LHU extraction
    drive_load(32'h1000_0003, 3'b000, 5'd7); tick(); idle();
    tick();
    chk("lb_wait_we", rf_we, 0);
    resp(32'h80FF_FF00); tick(); idle();
    chk("lb_we", rf_we, 1);
    chk("lb_waddr", rf_waddr, 7);
    chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    drive_load(32'h1000_0002, 3'b101, 5'd9); tick();
    resp(32'h80FF_FF00); tick(); idle();
    chk("lhu_wdata", rf_wdata, 32'h0000_80FF);
    chk("lhu_count", count, 0);

    // Order: LW rd2 then ADD rd3; response three cycles later
    drive_load(32'h0, 3'b010, 5'd2); tick();
    chk("ord_count1", count, 1);
    drive_alu(32'h0, 32'h33, 5'd3, 1, 0); tick(); idle();
    chk("ord_count2", count, 2);
    chk("ord_we_e2", rf_we, 0);
    tick();
    chk("ord_we_e3", rf_we, 0);
    tick();
    chk("ord_we_e4", rf_we, 0);
    resp(32'hDEAD_BEEF); tick(); idle();
    chk("ord_lw_waddr", rf_waddr, 2);
    chk("ord_lw_wdata", rf_wdata, 32'hDEAD_BEEF);
    chk("ord_count_after_lw", count, 1);
    tick();
    chk("ord_add_waddr", rf_waddr, 3);
    chk("ord_add_wdata", rf_wdata, 32'h33);
    chk("ord_count0", count, 0);

    // Four loads without responses fill the queue
    for (int i = 0; i < 4; i++) begin
      drive_load(32'h0, 3'b010, 5'(8 + i)); tick();
    end
    chk("full_count", count, 4);
    chk("full_ready", in_ready, 0);
    drive_alu(32'h0, 32'h77, 5'd20, 1, 0); tick(); idle();
    chk("full_reject_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      resp(32'h11 * (i + 1)); tick();
      chk("drain_waddr", rf_waddr, 8 + i);
      chk("drain_wdata", rf_wdata, 32'h11 * (i + 1));
    end
    idle();
    chk("drain_count", count, 0);

    // rd=0 write retires without strobe
    drive_alu(32'h0, 32'h55, 5'd0, 1, 0); tick(); idle();
    chk("rd0_count1", count, 1);
    tick();
    chk("rd0_we", rf_we, 0);
    chk("rd0_count0", count, 0);

    // Response with empty queue sets sticky error
    chk("err_before", resp_err, 0);
    resp(32'h1); tick(); idle();
    chk("err_set", resp_err, 1);
    tick(); tick();
    chk("err_sticky", resp_err, 1);

    // Response in the same cycle as a load's enqueue cannot fill it
    drive_load(32'h0, 3'b000, 5'd6);
    dc_resp_valid = 1; dc_resp_data = 32'h7F;
    tick(); idle();
    chk("same_cyc_count", count, 1);
    tick();
    chk("same_cyc_pending", count, 1);
    chk("same_cyc_we", rf_we, 0);
    resp(32'h0000_00FE); tick(); idle();
    chk("same_cyc_waddr", rf_waddr, 6);
    chk("same_cyc_wdata", rf_wdata, 32'hFFFF_FFFE);

    // Reset mid-stream with three entries pending
    for (int i = 0; i < 3; i++) begin
      drive_load(32'h0, 3'b010, 5'(12 + i)); tick();
    end
    drive_alu(32'h0, 32'h99, 5'd15, 1, 0); tick(); idle();
    resp(32'hAAAA_5555); tick(); idle();
    chk("pre_rst_we", rf_we, 1);
    chk("pre_rst_count", count, 3);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_wdata", rf_wdata, 0);
    chk("mid_rst_err", resp_err, 0);
    @(posedge clk); #1;
    rst_n = 1;
    tick();
    resp(32'h1234); tick(); idle();
    chk("late_resp_err", resp_err, 1);
    chk("late_resp_count", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
